// File: rtl/qei_speed.sv
// Velocity estimator. It samples a wrapping QEI count once per PERIOD and takes the signed delta.
// The delta is clamped to VBITS and smoothed by a 2^AVG_LOG2-deep moving average.
module qei_speed #(
    parameter int NBITS    = 16,
    parameter int PERIOD   = 48000,
    parameter int VBITS    = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [NBITS-1:0] qei_val,
    output logic [VBITS-1:0] vel,
    output logic             vel_valid,
    output logic             sat
);
    localparam int CW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = VBITS + AVG_LOG2;
    localparam logic signed [NBITS-1:0] VMAX = NBITS'((1 << (VBITS - 1)) - 1);
    localparam logic signed [NBITS-1:0] VMIN = ~VMAX;

    typedef enum logic {PRIME, RUN} state_t;

    state_t                   state_reg;
    logic [CW-1:0]            cnt_reg;
    logic [NBITS-1:0]         prev_reg;
    logic signed [VBITS-1:0]  delta_reg;
    logic                     s1_valid_reg;
    logic signed [VBITS-1:0]  hist_reg [DEPTH];
    logic signed [SW-1:0]     sum_reg;
    logic signed [SW-1:0]     sum_next;
    logic signed [VBITS-1:0]  vel_reg;
    logic                     vel_valid_reg;
    logic                     sat_reg;

    logic                     tick;
    logic signed [NBITS-1:0]  raw;
    logic signed [VBITS-1:0]  delta_next;
    logic                     clamp_hit;

    assign tick = en && (cnt_reg == CW'(PERIOD - 1));

    // Modular subtraction read as two's complement gives the correct delta across wrap.
    assign raw = signed'(qei_val - prev_reg);

    always_comb begin
        delta_next = raw[VBITS-1:0];
        clamp_hit  = 1'b0;
        if (raw > VMAX) begin
            delta_next = VMAX[VBITS-1:0];
            clamp_hit  = 1'b1;
        end else if (raw < VMIN) begin
            delta_next = VMIN[VBITS-1:0];
            clamp_hit  = 1'b1;
        end
    end

    assign sum_next = sum_reg + SW'(delta_reg) - SW'(hist_reg[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_reg     <= PRIME;
            cnt_reg       <= '0;
            prev_reg      <= '0;
            delta_reg     <= '0;
            s1_valid_reg  <= 1'b0;
            sum_reg       <= '0;
            vel_reg       <= '0;
            vel_valid_reg <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            vel_valid_reg <= 1'b0;
            s1_valid_reg  <= 1'b0;
            if (en) begin
                cnt_reg <= (cnt_reg == CW'(PERIOD - 1)) ? '0 : cnt_reg + CW'(1);
            end
            if (tick) begin
                prev_reg <= qei_val;
                if (state_reg == PRIME) begin
                    state_reg <= RUN;
                end else begin
                    delta_reg    <= delta_next;
                    s1_valid_reg <= 1'b1;
                    if (clamp_hit) begin
                        sat_reg <= 1'b1;
                    end
                end
            end
            // Stage 2 runs off s1_valid alone so a launched sample completes even with en low.
            if (s1_valid_reg) begin
                sum_reg       <= sum_next;
                vel_reg       <= VBITS'(sum_next >>> AVG_LOG2);
                vel_valid_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_reg[i] <= '0;
            end
        end else if (s1_valid_reg) begin
            hist_reg[0] <= delta_reg;
            for (int i = 1; i < DEPTH; i++) begin
                hist_reg[i] <= hist_reg[i-1];
            end
        end
    end

    assign vel       = vel_reg;
    assign vel_valid = vel_valid_reg;
    assign sat       = sat_reg;
endmodule

// File: tb/tb_qei_speed.sv
// Scoreboard bench for qei_speed: an averaging instance and a depth-1 instance share stimulus.
// Expected speeds are queued when each sample period is driven and popped whenever vel_valid fires.
module tb_qei_speed;
    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] qei_val = 16'd100;
    logic [11:0] vel_a, vel_b;
    logic        vv_a, vv_b, sat_a, sat_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int vel;
        int cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    qei_speed #(.NBITS(16), .PERIOD(PERIOD), .VBITS(12), .AVG_LOG2(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .qei_val(qei_val),
        .vel(vel_a), .vel_valid(vv_a), .sat(sat_a)
    );

    qei_speed #(.NBITS(16), .PERIOD(PERIOD), .VBITS(12), .AVG_LOG2(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .qei_val(qei_val),
        .vel(vel_b), .vel_valid(vv_b), .sat(sat_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vv_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", int'(vv_a), 0);
            end else begin
                e = q_a.pop_front();
                check("a_vel", $signed(vel_a), e.vel);
                check("a_cycle", cyc, e.cyc);
                $display("a: vel=%0d at cycle %0d (expected %0d at %0d)", $signed(vel_a), cyc, e.vel, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (vv_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_valid", int'(vv_b), 0);
            end else begin
                e = q_b.pop_front();
                check("b_vel", $signed(vel_b), e.vel);
                check("b_cycle", cyc, e.cyc);
                $display("b: vel=%0d at cycle %0d (expected %0d at %0d)", $signed(vel_b), cyc, e.vel, e.cyc);
            end
        end
    end

    // One sample period, aligned so that its last edge is the tick; vel_valid lands one edge later.
    task automatic period(input logic [15:0] v, input bit push, input int ea, input int eb);
        int s;
        qei_val = v;
        s = cyc;
        if (push) begin
            q_a.push_back('{ea, s + PERIOD + 1});
            q_b.push_back('{eb, s + PERIOD + 1});
        end
        repeat (PERIOD) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_vel_a", $signed(vel_a), 0);
        check("rst_sat_a", int'(sat_a), 0);
        check("rst_valid_a", int'(vv_a), 0);
        check("rst_vel_b", $signed(vel_b), 0);
        check("rst_sat_b", int'(sat_b), 0);

        // Prime, zero delta, then constant +5 per period.
        period(16'd100, 1'b0, 0, 0);
        period(16'd100, 1'b1, 0, 0);
        period(16'd105, 1'b1, 1, 5);
        period(16'd110, 1'b1, 2, 5);
        period(16'd115, 1'b1, 3, 5);
        period(16'd120, 1'b1, 5, 5);
        period(16'd125, 1'b1, 5, 5);
        check("fwd_sat_a", int'(sat_a), 0);

        // Wrap-around in both directions.
        clr_pulse();
        period(16'hFFFE, 1'b0, 0, 0);
        period(16'h0003, 1'b1, 1, 5);
        period(16'h0002, 1'b1, 1, -1);
        period(16'hFFFD, 1'b1, -1, -5);

        // Saturation both ways; sat sticks until clr.
        clr_pulse();
        period(16'd0, 1'b0, 0, 0);
        period(16'd3000, 1'b1, 511, 2047);
        period(16'd0, 1'b1, -1, -2048);
        repeat (3) @(posedge clk);
        #1;
        check("sat_set_a", int'(sat_a), 1);
        check("sat_set_b", int'(sat_b), 1);
        clr_pulse();
        check("sat_clr_a", int'(sat_a), 0);
        check("sat_clr_b", int'(sat_b), 0);
        check("clr_vel_b", $signed(vel_b), 0);

        // Negative constant speed, floor rounding.
        period(16'd1000, 1'b0, 0, 0);
        period(16'd995, 1'b1, -2, -5);
        period(16'd990, 1'b1, -3, -5);
        period(16'd985, 1'b1, -4, -5);
        period(16'd980, 1'b1, -5, -5);

        // en low right after a tick: pending sample still completes, prescaler holds.
        en = 1'b0;
        repeat (25) @(posedge clk);
        #1 en = 1'b1;
        period(16'd975, 1'b1, -5, -5);

        // clr landing on the tick edge suppresses the sample and re-primes.
        qei_val = 16'd970;
        repeat (PERIOD - 1) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("tickclr_vel_a", $signed(vel_a), 0);
        check("tickclr_vel_b", $signed(vel_b), 0);
        period(16'd500, 1'b0, 0, 0);
        period(16'd507, 1'b1, 1, 7);

        repeat (5) @(posedge clk);
        #1;
        check("a_pending", q_a.size(), 0);
        check("b_pending", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
